// File: rtl/sdspi_blk_reader.sv
// Wishbone master that reads one sector through the sdspi core and streams the words out on valid/ready.
// Optional poll timeout when SDSPI_BLKRD_TIMEOUT_EN is defined; without it POLL waits indefinitely.
module sdspi_blk_reader #(
    parameter logic [31:0] READ_CMD = 32'h0000_8851,
    parameter int          BUSY_BIT = 14,
    parameter int          ERR_BIT  = 15,
    parameter int          WORDS    = 128
`ifdef SDSPI_BLKRD_TIMEOUT_EN
    ,
    parameter int          POLL_LIMIT = 1_000_000
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] sector,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        wb_cyc,
    output logic        wb_stb,
    output logic        wb_we,
    output logic [1:0]  wb_adr,
    output logic [31:0] wb_dat_w,
    output logic [3:0]  wb_sel,
    input  logic        wb_stall,
    input  logic        wb_ack,
    input  logic [31:0] wb_dat_r,
    output logic [31:0] m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_last
);

    localparam int            CW         = $clog2(WORDS);
    localparam logic [CW-1:0] LAST_IDX   = CW'(WORDS - 1);
    localparam logic [1:0]    ADR_CMD    = 2'd0;
    localparam logic [1:0]    ADR_DATA   = 2'd1;
    localparam logic [1:0]    ADR_FIFO_A = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_DATA,
        S_WR_CMD,
        S_POLL,
        S_RD_FIFO,
        S_OUT,
        S_DONE,
        S_FAIL
    } state_t;

    state_t        state_q, state_d;
    logic          cyc_q, cyc_d;
    logic          stb_q, stb_d;
    logic          we_q, we_d;
    logic [1:0]    adr_q, adr_d;
    logic [31:0]   dat_w_q, dat_w_d;
    logic [31:0]   sector_q, sector_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   m_data_q, m_data_d;
    logic          m_valid_q, m_valid_d;

`ifdef SDSPI_BLKRD_TIMEOUT_EN
    localparam logic [19:0] POLL_LIM = 20'(POLL_LIMIT);
    logic [19:0]   poll_cnt_q, poll_cnt_d;
`endif

    logic          acc_state;
    logic          acc_we;
    logic [1:0]    acc_adr;
    logic [31:0]   acc_dat;
    logic          acc_done;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cyc_q     <= 1'b0;
            stb_q     <= 1'b0;
            we_q      <= 1'b0;
            adr_q     <= 2'd0;
            dat_w_q   <= 32'd0;
            sector_q  <= 32'd0;
            cnt_q     <= '0;
            m_data_q  <= 32'd0;
            m_valid_q <= 1'b0;
`ifdef SDSPI_BLKRD_TIMEOUT_EN
            poll_cnt_q <= 20'd0;
`endif
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            stb_q     <= stb_d;
            we_q      <= we_d;
            adr_q     <= adr_d;
            dat_w_q   <= dat_w_d;
            sector_q  <= sector_d;
            cnt_q     <= cnt_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
`ifdef SDSPI_BLKRD_TIMEOUT_EN
            poll_cnt_q <= poll_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q;
        stb_d     = stb_q;
        we_d      = we_q;
        adr_d     = adr_q;
        dat_w_d   = dat_w_q;
        sector_d  = sector_q;
        cnt_d     = cnt_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;
`ifdef SDSPI_BLKRD_TIMEOUT_EN
        poll_cnt_d = poll_cnt_q;
`endif
        acc_state = 1'b0;
        acc_we    = 1'b0;
        acc_adr   = ADR_CMD;
        acc_dat   = dat_w_q;
        acc_done  = 1'b0;

        case (state_q)
            S_WR_DATA: begin
                acc_state = 1'b1;
                acc_we    = 1'b1;
                acc_adr   = ADR_DATA;
                acc_dat   = sector_q;
            end
            S_WR_CMD: begin
                acc_state = 1'b1;
                acc_we    = 1'b1;
                acc_adr   = ADR_CMD;
                acc_dat   = READ_CMD;
            end
            S_POLL: begin
                acc_state = 1'b1;
                acc_adr   = ADR_CMD;
            end
            S_RD_FIFO: begin
                acc_state = 1'b1;
                acc_adr   = ADR_FIFO_A;
            end
            default: ;
        endcase

        // A state with cyc low has not launched its access yet; launching only
        // from cyc low guarantees the idle gap after every ack.
        if (acc_state) begin
            if (!cyc_q) begin
                cyc_d   = 1'b1;
                stb_d   = 1'b1;
                we_d    = acc_we;
                adr_d   = acc_adr;
                dat_w_d = acc_dat;
            end else begin
                if (stb_q && !wb_stall) begin
                    stb_d = 1'b0;
                end
                if (wb_ack) begin
                    cyc_d    = 1'b0;
                    stb_d    = 1'b0;
                    acc_done = 1'b1;
                end
            end
        end

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    sector_d = sector;
                    state_d  = S_WR_DATA;
                end
            end
            S_WR_DATA: begin
                if (acc_done) begin
                    state_d = S_WR_CMD;
                end
            end
            S_WR_CMD: begin
                if (acc_done) begin
                    state_d = S_POLL;
`ifdef SDSPI_BLKRD_TIMEOUT_EN
                    poll_cnt_d = 20'd0;
`endif
                end
            end
            S_POLL: begin
                if (acc_done) begin
                    if (wb_dat_r[ERR_BIT]) begin
                        state_d = S_FAIL;
                    end else if (wb_dat_r[BUSY_BIT]) begin
`ifdef SDSPI_BLKRD_TIMEOUT_EN
                        if (poll_cnt_q + 20'd1 == POLL_LIM) begin
                            state_d = S_FAIL;
                        end else begin
                            poll_cnt_d = poll_cnt_q + 20'd1;
                            state_d    = S_POLL;
                        end
`else
                        state_d = S_POLL;
`endif
                    end else begin
                        state_d = S_RD_FIFO;
                    end
                end
            end
            S_RD_FIFO: begin
                if (acc_done) begin
                    m_data_d  = wb_dat_r;
                    m_valid_d = 1'b1;
                    state_d   = S_OUT;
                end
            end
            S_OUT: begin
                // No bus activity here, so a stalled consumer stalls the FIFO reads.
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    if (cnt_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = S_RD_FIFO;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            S_FAIL: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // busy drops in the DONE/FAIL cycle so it falls together with the pulse.
    assign busy     = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_FAIL);
    assign done     = (state_q == S_DONE);
    assign err      = (state_q == S_FAIL);
    assign wb_cyc   = cyc_q;
    assign wb_stb   = stb_q;
    assign wb_we    = we_q;
    assign wb_adr   = adr_q;
    assign wb_dat_w = dat_w_q;
    assign wb_sel   = 4'hF;
    assign m_data   = m_data_q;
    assign m_valid  = m_valid_q;
    assign m_last   = m_valid_q && (cnt_q == LAST_IDX);

endmodule

// File: tb/tb_sdspi_blk_reader.sv
// Self-checking bench for sdspi_blk_reader: a Wishbone sdspi slave model, a stream sink and a scoreboard.
module tb_sdspi_blk_reader;

    localparam int WORDS = 128;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] sector = 32'd0;
    logic        busy, done, err;
    logic        wb_cyc, wb_stb, wb_we;
    logic [1:0]  wb_adr;
    logic [31:0] wb_dat_w;
    logic [3:0]  wb_sel;
    logic        wb_stall = 1'b0;
    logic        wb_ack = 1'b0;
    logic [31:0] wb_dat_r = 32'd0;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic        m_last;

`ifdef SDSPI_BLKRD_TIMEOUT_EN
    sdspi_blk_reader #(.POLL_LIMIT(16)) dut (
`else
    sdspi_blk_reader dut (
`endif
        .clk(clk), .rst_n(rst_n), .start(start), .sector(sector),
        .busy(busy), .done(done), .err(err),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
        .wb_dat_w(wb_dat_w), .wb_sel(wb_sel), .wb_stall(wb_stall),
        .wb_ack(wb_ack), .wb_dat_r(wb_dat_r),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc_no = 0;

    // slave configuration
    int busy_polls = 3;
    bit err_mode = 0;
    bit stall_en = 0;
    int ready_mode = 0;

    // slave logs
    int          polls, fifo_reads, accepts;
    logic [1:0]  wr_adr_q[$];
    logic [31:0] wr_dat_q[$];

    // sink/monitor logs
    logic [31:0] got[$];
    int done_cnt, err_cnt, valid_cnt, last_bad, last_cnt, stable_bad;
    int cyc_in_out, busy_bad, stb_bad, sel_bad, first_valid_cyc;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time exhausted");
        $fatal(1);
    end

    // sdspi slave: accepts at a non-stalled strobe, acks the following cycle
    initial begin
        bit          acc;
        logic        we_s;
        logic [1:0]  adr_s;
        logic [31:0] dw_s;
        int          stall_left;
        bit          stalled;
        int          poll_n;
        int          fifo_idx;
        stall_left = 0;
        stalled = 0;
        poll_n = 0;
        fifo_idx = 0;
        forever begin
            @(negedge clk);
            acc   = wb_cyc && wb_stb && !wb_stall;
            we_s  = wb_we;
            adr_s = wb_adr;
            dw_s  = wb_dat_w;
            @(posedge clk);
            cyc_no++;
            #1;
            wb_ack   = 1'b0;
            wb_dat_r = 32'd0;
            if (acc) begin
                wb_ack = 1'b1;
                accepts++;
                stalled = 0;
                if (we_s) begin
                    wr_adr_q.push_back(adr_s);
                    wr_dat_q.push_back(dw_s);
                    if (adr_s == 2'd0) begin
                        poll_n = 0;
                        fifo_idx = 0;
                    end
                end else if (adr_s == 2'd0) begin
                    polls++;
                    poll_n++;
                    if (err_mode) wb_dat_r = 32'h0000_8000;
                    else if (poll_n <= busy_polls) wb_dat_r = 32'h0000_4000;
                end else if (adr_s == 2'd2) begin
                    fifo_reads++;
                    wb_dat_r = 32'h1000_0000 + 32'(fifo_idx);
                    fifo_idx++;
                end
            end
            if (!wb_cyc) stalled = 0;
            if (stall_en && wb_cyc && wb_stb && !stalled && stall_left == 0) begin
                stall_left = 5;
                stalled = 1;
            end
            wb_stall = (stall_left > 0);
            if (stall_left > 0) stall_left--;
            case (ready_mode)
                0: m_ready = 1'b1;
                1: m_ready = (cyc_no % 3 != 0);
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // stream sink and protocol monitor
    initial begin
        bit          pst;
        logic [31:0] pd;
        bit          pstb;
        pst = 0;
        pd = 32'd0;
        pstb = 0;
        forever begin
            @(negedge clk);
            if (m_valid && m_ready) begin
                got.push_back(m_data);
                if (m_last !== (got.size() == WORDS)) last_bad++;
                if (m_last) last_cnt++;
            end
            if (m_last && !m_valid) last_bad++;
            if (pst && rst_n && (m_valid !== 1'b1 || m_data !== pd)) stable_bad++;
            pst = m_valid && !m_ready && rst_n;
            pd  = m_data;
            if (m_valid && wb_cyc) cyc_in_out++;
            if (m_valid) begin
                valid_cnt++;
                if (first_valid_cyc < 0) first_valid_cyc = cyc_no;
            end
            if (done) done_cnt++;
            if (err) err_cnt++;
            if ((done || err) && busy) busy_bad++;
            if (wb_sel !== 4'hF) sel_bad++;
            if (pstb && rst_n && wb_stb !== 1'b1) stb_bad++;
            pstb = wb_stb && wb_stall && rst_n;
        end
    end

    task automatic clear_logs();
        polls = 0; fifo_reads = 0; accepts = 0;
        wr_adr_q.delete(); wr_dat_q.delete(); got.delete();
        done_cnt = 0; err_cnt = 0; valid_cnt = 0; last_bad = 0; last_cnt = 0;
        stable_bad = 0; cyc_in_out = 0; busy_bad = 0; stb_bad = 0; sel_bad = 0;
        first_valid_cyc = -1;
    endtask

    task automatic pulse_start(input logic [31:0] s, output int samp);
        @(posedge clk); #1;
        sector = s;
        start = 1'b1;
        samp = cyc_no + 1;
        @(posedge clk); #1;
        start = 1'b0;
        sector = $urandom;
    endtask

    task automatic wait_end(input string name, input int budget);
        int n;
        n = 0;
        while (done_cnt + err_cnt == 0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (done_cnt + err_cnt == 0) begin
            errors++;
            $display("FAIL %s_timeout: no done/err after %0d cycles, required one", name, budget);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, err, wb_cyc, wb_stb, wb_we, m_valid, m_last, wb_adr, wb_dat_w, m_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy%b done%b err%b cyc%b stb%b we%b vld%b last%b adr%h dat%h m%h, required all zero",
                     busy, done, err, wb_cyc, wb_stb, wb_we, m_valid, m_last, wb_adr, wb_dat_w, m_data);
        end
        checks++;
        if (wb_sel !== 4'hF) begin
            errors++;
            $display("FAIL reset_sel: got %h required f", wb_sel);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int samp;
        clear_logs();
        busy_polls = 3; err_mode = 0; stall_en = 0; ready_mode = 0;
        pulse_start(32'h0000_0042, samp);
        wait_end("basic", 3000);
        checks++;
        if (wr_adr_q.size() != 2 || wr_adr_q[0] !== 2'd1 || wr_dat_q[0] !== 32'h42 ||
            wr_adr_q[1] !== 2'd0 || wr_dat_q[1] !== 32'h8851) begin
            errors++;
            $display("FAIL basic_writes: %0d writes, first adr%h dat%h, required DATA=42 then CMD=8851",
                     wr_adr_q.size(), wr_adr_q.size() > 0 ? wr_adr_q[0] : 2'bx, wr_dat_q.size() > 0 ? wr_dat_q[0] : 32'bx);
        end
        checks++;
        if (polls != 4) begin
            errors++;
            $display("FAIL basic_polls: got %0d required 4", polls);
        end
        checks++;
        if (got.size() != WORDS) begin
            errors++;
            $display("FAIL basic_count: got %0d words required %0d", got.size(), WORDS);
        end
        for (int i = 0; i < WORDS && i < got.size(); i++) begin
            checks++;
            if (got[i] !== 32'h1000_0000 + 32'(i)) begin
                errors++;
                $display("FAIL basic_word[%0d]: got %h required %h", i, got[i], 32'h1000_0000 + 32'(i));
            end
        end
        checks++;
        if (last_cnt != 1 || last_bad != 0) begin
            errors++;
            $display("FAIL basic_last: %0d m_last handshakes, %0d misplaced, required 1 and 0", last_cnt, last_bad);
        end
        checks++;
        if (done_cnt != 1 || err_cnt != 0 || busy_bad != 0) begin
            errors++;
            $display("FAIL basic_done: done %0d err %0d busy_at_pulse %0d, required 1 0 0", done_cnt, err_cnt, busy_bad);
        end
        checks++;
        if (first_valid_cyc - samp != 12 + 3 * busy_polls) begin
            errors++;
            $display("FAIL basic_latency: got %0d cycles required %0d", first_valid_cyc - samp, 12 + 3 * busy_polls);
        end
    endtask

    task automatic test_backpressure();
        int samp;
        int bad;
        clear_logs();
        busy_polls = 3; ready_mode = 1;
        pulse_start($urandom, samp);
        wait_end("bp", 4000);
        bad = 0;
        for (int i = 0; i < got.size(); i++)
            if (got[i] !== 32'h1000_0000 + 32'(i)) bad++;
        checks++;
        if (got.size() != WORDS || bad != 0) begin
            errors++;
            $display("FAIL bp_words: %0d words, %0d wrong, required %0d and 0", got.size(), bad, WORDS);
        end
        checks++;
        if (stable_bad != 0) begin
            errors++;
            $display("FAIL bp_stable: %0d changes while stalled, required 0", stable_bad);
        end
        checks++;
        if (cyc_in_out != 0 || fifo_reads != WORDS) begin
            errors++;
            $display("FAIL bp_bus: cyc in OUT %0d, fifo reads %0d, required 0 and %0d", cyc_in_out, fifo_reads, WORDS);
        end
        ready_mode = 0;
    endtask

    task automatic test_err();
        int samp;
        clear_logs();
        err_mode = 1;
        pulse_start($urandom, samp);
        wait_end("err", 500);
        checks++;
        if (err_cnt != 1 || done_cnt != 0) begin
            errors++;
            $display("FAIL err_pulse: err %0d done %0d, required 1 0", err_cnt, done_cnt);
        end
        checks++;
        if (valid_cnt != 0 || fifo_reads != 0) begin
            errors++;
            $display("FAIL err_nodata: m_valid cycles %0d fifo reads %0d, required 0 0", valid_cnt, fifo_reads);
        end
        checks++;
        if (busy_bad != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL err_busy: busy at pulse %0d, busy now %b, required 0 0", busy_bad, busy);
        end
        err_mode = 0;
    endtask

    task automatic test_stall();
        int samp;
        int bad;
        clear_logs();
        busy_polls = 3; stall_en = 1;
        pulse_start(32'hCAFE_0001, samp);
        wait_end("stall", 5000);
        checks++;
        if (stb_bad != 0) begin
            errors++;
            $display("FAIL stall_stb: stb dropped under stall %0d times, required 0", stb_bad);
        end
        checks++;
        if (accepts != 2 + 4 + WORDS) begin
            errors++;
            $display("FAIL stall_accepts: got %0d required %0d", accepts, 2 + 4 + WORDS);
        end
        bad = 0;
        for (int i = 0; i < got.size(); i++)
            if (got[i] !== 32'h1000_0000 + 32'(i)) bad++;
        checks++;
        if (got.size() != WORDS || bad != 0 || wr_dat_q.size() == 0 || wr_dat_q[0] !== 32'hCAFE_0001) begin
            errors++;
            $display("FAIL stall_data: %0d words, %0d wrong, sector write ok=%b", got.size(), bad,
                     wr_dat_q.size() > 0 && wr_dat_q[0] === 32'hCAFE_0001);
        end
        stall_en = 0;
    endtask

    task automatic test_reset_mid();
        int samp;
        int n;
        int bad;
        logic [31:0] sec;
        clear_logs();
        busy_polls = 1; ready_mode = 0;
        pulse_start($urandom, samp);
        n = 0;
        while (got.size() < 60 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (got.size() < 60) begin
            errors++;
            $display("FAIL rstmid_reach: got %0d words required 60", got.size());
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({busy, done, err, wb_cyc, wb_stb, wb_we, m_valid, m_last, wb_adr, wb_dat_w, m_data} !== '0) begin
            errors++;
            $display("FAIL rstmid_outputs: busy%b cyc%b stb%b vld%b last%b adr%h dat%h m%h, required all zero",
                     busy, wb_cyc, wb_stb, m_valid, m_last, wb_adr, wb_dat_w, m_data);
        end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        clear_logs();
        sec = $urandom;
        pulse_start(sec, samp);
        repeat (3) @(posedge clk);
        pulse_start(~sec, samp);
        wait_end("rstmid", 3000);
        repeat (10) @(posedge clk);
        #1;
        bad = 0;
        for (int i = 0; i < got.size(); i++)
            if (got[i] !== 32'h1000_0000 + 32'(i)) bad++;
        checks++;
        if (got.size() != WORDS || bad != 0) begin
            errors++;
            $display("FAIL rstmid_words: %0d words, %0d wrong, required %0d from index 0", got.size(), bad, WORDS);
        end
        checks++;
        if (wr_dat_q.size() != 2 || wr_dat_q[0] !== sec || done_cnt != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_ignore_start: writes %0d sector %h done %0d busy %b, required 2 %h 1 0",
                     wr_dat_q.size(), wr_dat_q.size() > 0 ? wr_dat_q[0] : 32'bx, done_cnt, busy, sec);
        end
    endtask

    task automatic test_back_to_back();
        int samp;
        int bad;
        logic [31:0] sec;
        for (int it = 0; it < 3; it++) begin
            clear_logs();
            busy_polls = $urandom_range(0, 3);
            ready_mode = (it == 1) ? 2 : 0;
            sec = $urandom;
            pulse_start(sec, samp);
            wait_end("b2b", 4000);
            bad = 0;
            for (int i = 0; i < got.size(); i++)
                if (got[i] !== 32'h1000_0000 + 32'(i)) bad++;
            checks++;
            if (got.size() != WORDS || bad != 0 || last_bad != 0 || stable_bad != 0) begin
                errors++;
                $display("FAIL b2b_stream[%0d]: %0d words %0d wrong last_bad %0d unstable %0d", it,
                         got.size(), bad, last_bad, stable_bad);
            end
            checks++;
            if (wr_dat_q.size() != 2 || wr_dat_q[0] !== sec || polls != busy_polls + 1) begin
                errors++;
                $display("FAIL b2b_bus[%0d]: writes %0d polls %0d, required 2 and %0d", it,
                         wr_dat_q.size(), polls, busy_polls + 1);
            end
            checks++;
            if (first_valid_cyc - samp != 12 + 3 * busy_polls) begin
                errors++;
                $display("FAIL b2b_latency[%0d]: got %0d required %0d", it, first_valid_cyc - samp, 12 + 3 * busy_polls);
            end
        end
        ready_mode = 0;
    endtask

    task automatic test_poll_limit();
        int samp;
        int n;
        clear_logs();
        busy_polls = 1_000_000;
        pulse_start($urandom, samp);
`ifdef SDSPI_BLKRD_TIMEOUT_EN
        wait_end("timeout", 500);
        checks++;
        if (err_cnt != 1 || polls != 16 || valid_cnt != 0) begin
            errors++;
            $display("FAIL timeout_err: err %0d polls %0d valid %0d, required 1 16 0", err_cnt, polls, valid_cnt);
        end
`else
        n = 0;
        while (polls < 1000 && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (polls < 1000 || err_cnt != 0 || valid_cnt != 0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL nolimit_polls: polls %0d err %0d valid %0d busy %b, required >=1000 0 0 1",
                     polls, err_cnt, valid_cnt, busy);
        end
`endif
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        busy_polls = 3;
        @(posedge clk); #1;
    endtask

    initial begin
        clear_logs();
        test_reset();
        test_basic();
        test_backpressure();
        test_err();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        test_poll_limit();
        checks++;
        if (sel_bad != 0) begin
            errors++;
            $display("FAIL sel_const: wb_sel off 4'hF in %0d cycles", sel_bad);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
